// File: rtl/geiger_event_timestamper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : geiger_event_timestamper
// Purpose  : Synchronises the raw geiger tube pulse, detects rising edges and
//            stamps each event with the 48-bit mission time. Stamps are held
//            in a first-word-fall-through FIFO and offered on a valid/ready
//            port to the downstream packetiser.
// Ports    : CLK_1MHZ    in   1   system clock (1 MHz)
//            RESET       in   1   synchronous, active-high reset
//            GEIG_IN     in   1   raw tube pulse, asynchronous, >= 1 cycle wide
//            TIMESTAMP   in  48   mission time in us, same clock domain
//            TS_DATA     out 48   stamp at FIFO head (0 while empty)
//            TS_VALID    out  1   FIFO non-empty
//            TS_READY    in   1   consumer accepts TS_DATA this cycle
//            FILL_LEVEL  out  7   entries held, 0..FIFO_DEPTH
//            DROP_CNT    out 16   events lost to a full FIFO, saturating
// Config   : define GEIG_DEADTIME_EN to ignore edges for DEADTIME_CYC cycles
//            after every accepted or dropped event.
// Revision : 1.0 - initial release
// ============================================================================
module geiger_event_timestamper #(
    parameter int FIFO_DEPTH   = 8,
    parameter int DEADTIME_CYC = 50
) (
    input  logic        CLK_1MHZ,
    input  logic        RESET,
    input  logic        GEIG_IN,
    input  logic [47:0] TIMESTAMP,
    output logic [47:0] TS_DATA,
    output logic        TS_VALID,
    input  logic        TS_READY,
    output logic [6:0]  FILL_LEVEL,
    output logic [15:0] DROP_CNT
);

    localparam int         c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [6:0] c_depth = 7'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DEADTIME_CYC < 1) begin : g_param_check
        $error("geiger_event_timestamper: FIFO_DEPTH must be a power of two in 2..64, DEADTIME_CYC >= 1");
    end

    // ------------------------------------------------------------------
    // Synchroniser and edge detector
    // ------------------------------------------------------------------
    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [1:0] r_sync_vld;
    logic       w_edge;
    logic       w_event;

    // The synchroniser restarts from 0 after reset, so for the first two
    // cycles r_sync2 does not reflect the pin. r_prev is held at 1 until the
    // pipeline carries real samples; the first real sample becomes the
    // baseline, which keeps a pin held high across reset from being seen
    // as a fresh rising edge.
    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b1;
            r_sync_vld <= 2'b00;
        end else begin
            r_sync1    <= GEIG_IN;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_prev     <= r_sync_vld[1] ? r_sync2 : 1'b1;
        end
    end

    assign w_edge = r_sync2 & ~r_prev;

    // ------------------------------------------------------------------
    // Optional dead time after each event
    // ------------------------------------------------------------------
`ifdef GEIG_DEADTIME_EN
    localparam int c_dead_w = $clog2(DEADTIME_CYC + 1);
    logic [c_dead_w-1:0] r_dead_cnt;

    // Loaded with DEADTIME_CYC-1 in the event cycle, so edges in the next
    // DEADTIME_CYC-1 cycles are swallowed and one arriving exactly
    // DEADTIME_CYC cycles later sees a zero count and is accepted.
    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            r_dead_cnt <= '0;
        end else if (w_event) begin
            r_dead_cnt <= c_dead_w'(DEADTIME_CYC - 1);
        end else if (r_dead_cnt != '0) begin
            r_dead_cnt <= r_dead_cnt - 1'b1;
        end
    end

    assign w_event = w_edge & (r_dead_cnt == '0);
`else
    assign w_event = w_edge;
`endif

    // ------------------------------------------------------------------
    // Stamp FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [47:0]        r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [6:0]         r_count;
    logic [15:0]        r_drop_cnt;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_empty = (r_count == 7'd0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = ~w_empty & TS_READY;
    // A full FIFO still accepts an event when the head leaves this cycle;
    // the write then lands in the slot the pop frees.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    always_ff @(posedge CLK_1MHZ) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= TIMESTAMP;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 7'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 7'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 7'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign TS_DATA    = w_empty ? 48'd0 : r_mem[r_rd_ptr];
    assign TS_VALID   = ~w_empty;
    assign FILL_LEVEL = r_count;
    assign DROP_CNT   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_geiger_event_timestamper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_geiger_event_timestamper
// Purpose  : Self-checking bench for geiger_event_timestamper. A queue-based
//            reference model tracks expected stamps, fill level and drop
//            count; directed scenarios plus a randomized run compare the DUT
//            against it. Honours GEIG_DEADTIME_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_geiger_event_timestamper;

    localparam int c_depth = 8;
    localparam int c_dead  = 50;
`ifdef GEIG_DEADTIME_EN
    localparam bit c_dead_on  = 1'b1;
    localparam int c_gap_slow = c_dead + 2;
    localparam int c_gap_fast = c_dead + 2;
`else
    localparam bit c_dead_on  = 1'b0;
    localparam int c_gap_slow = 4;
    localparam int c_gap_fast = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        geig_in;
    logic        ts_ready;
    logic [47:0] ts_base;
    logic [47:0] tb_cyc = '0;
    wire  [47:0] w_ts = ts_base + tb_cyc;
    logic [47:0] w_ts_data;
    logic        w_ts_valid;
    logic [6:0]  w_fill;
    logic [15:0] w_drop;

    int checks;
    int failures;

    always #500 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 48'd1;

    geiger_event_timestamper #(
        .FIFO_DEPTH  (c_depth),
        .DEADTIME_CYC(c_dead)
    ) dut (
        .CLK_1MHZ  (clk),
        .RESET     (rst),
        .GEIG_IN   (geig_in),
        .TIMESTAMP (w_ts),
        .TS_DATA   (w_ts_data),
        .TS_VALID  (w_ts_valid),
        .TS_READY  (ts_ready),
        .FILL_LEVEL(w_fill),
        .DROP_CNT  (w_drop)
    );

    // ------------------------------------------------------------------
    // Reference model: a rise driven before clock edge k becomes an event
    // at edge k+2 (third edge after the rise) and stores the TIMESTAMP of
    // that edge. Queue of stamps with capacity c_depth, pop before push.
    // ------------------------------------------------------------------
    logic [47:0] m_fifo[$];
    logic [47:0] m_pend[$];
    logic [15:0] m_drop;
    logic        m_have_last;
    logic [47:0] m_last;

    always @(posedge clk) begin : model
        logic ev;
        if (rst) begin
            m_fifo.delete();
            m_pend.delete();
            m_drop      = '0;
            m_have_last = 1'b0;
            m_last      = '0;
        end else begin
            ev = 1'b0;
            while (m_pend.size() != 0 && m_pend[0] <= tb_cyc) begin
                if (m_pend[0] == tb_cyc) ev = 1'b1;
                void'(m_pend.pop_front());
            end
            if (ev && c_dead_on && m_have_last && ((tb_cyc - m_last) < 48'(c_dead))) ev = 1'b0;
            if (ev) begin
                m_have_last = 1'b1;
                m_last      = tb_cyc;
            end
            if (m_fifo.size() != 0 && ts_ready) void'(m_fifo.pop_front());
            if (ev) begin
                if (m_fifo.size() < c_depth) m_fifo.push_back(w_ts);
                else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end on a falling clock edge)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rise();
        geig_in = 1'b1;
        m_pend.push_back(tb_cyc + 48'd2);
    endtask

    task automatic pulse(input int hi, input int lo);
        rise();
        idle(hi);
        geig_in = 1'b0;
        idle(lo);
    endtask

    task automatic do_reset();
        geig_in = 1'b0;
        ts_ready = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(3);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        geig_in = 1'b0;
        idle(2);
        checks++; if (w_ts_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", w_ts_valid); end
        checks++; if (w_fill !== 7'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", w_fill); end
        checks++; if (w_drop !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", w_drop); end
        checks++; if (w_ts_data !== 48'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", w_ts_data); end
        rst = 1'b0;
        idle(3);
        checks++; if (w_ts_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", w_ts_valid); end
        checks++; if (w_fill !== 7'd0) begin failures++; $display("FAIL post_reset_fill got=%0d exp=0", w_fill); end
    endtask

    task automatic test_single();
        int          vcnt;
        int          first_v;
        logic [47:0] got;
        logic [6:0]  fill_at_v;
        do_reset();
        ts_ready = 1'b1;
        ts_base = 48'd10000 - tb_cyc;
        idle(1);
        vcnt = 0; first_v = -1; got = '0; fill_at_v = '0;
        rise();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) geig_in = 1'b0;
            if (w_ts_valid) begin
                vcnt++;
                got = w_ts_data;
                fill_at_v = w_fill;
                if (first_v < 0) first_v = i;
            end
        end
        checks++; if (vcnt != 1) begin failures++; $display("FAIL single_valid_cycles got=%0d exp=1", vcnt); end
        checks++; if (got !== 48'd10003) begin failures++; $display("FAIL single_stamp got=%0d exp=10003", got); end
        checks++; if (first_v != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", first_v); end
        checks++; if (fill_at_v !== 7'd1) begin failures++; $display("FAIL single_fill_peak got=%0d exp=1", fill_at_v); end
        checks++; if (w_fill !== 7'd0) begin failures++; $display("FAIL single_fill_end got=%0d exp=0", w_fill); end
    endtask

    task automatic test_backpressure();
        logic [47:0] exp_s[10];
        logic [47:0] prev;
        int          n;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            exp_s[i] = w_ts + 48'd2;
            pulse(c_gap_slow / 2, c_gap_slow - c_gap_slow / 2);
        end
        idle(4);
        checks++; if (w_fill !== 7'd8) begin failures++; $display("FAIL bp_fill got=%0d exp=8", w_fill); end
        checks++; if (w_drop !== 16'd2) begin failures++; $display("FAIL bp_drop got=%0d exp=2", w_drop); end
        ts_ready = 1'b1;
        n = 0; prev = '0;
        for (int i = 0; i < 12; i++) begin
            if (w_ts_valid) begin
                checks++;
                if (n >= 8) begin failures++; $display("FAIL bp_extra_stamp got=%0d exp=none", w_ts_data); end
                else if (w_ts_data !== exp_s[n]) begin failures++; $display("FAIL bp_stamp%0d got=%0d exp=%0d", n, w_ts_data, exp_s[n]); end
                if (n > 0) begin
                    checks++;
                    if (!(w_ts_data > prev)) begin failures++; $display("FAIL bp_order%0d got=%0d prev=%0d", n, w_ts_data, prev); end
                end
                prev = w_ts_data;
                n++;
            end
            @(negedge clk);
        end
        ts_ready = 1'b0;
        checks++; if (n != 8) begin failures++; $display("FAIL bp_drain_count got=%0d exp=8", n); end
        checks++; if (w_fill !== 7'd0) begin failures++; $display("FAIL bp_fill_end got=%0d exp=0", w_fill); end
    endtask

    task automatic test_full_pop();
        logic [47:0] exp_s[9];
        int          n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_s[i] = w_ts + 48'd2;
            pulse(c_gap_slow / 2, c_gap_slow - c_gap_slow / 2);
        end
        idle(3);
        checks++; if (w_fill !== 7'd8) begin failures++; $display("FAIL fp_full got=%0d exp=8", w_fill); end
        exp_s[8] = w_ts + 48'd2;
        rise();
        idle(2);
        ts_ready = 1'b1;
        idle(1);
        ts_ready = 1'b0;
        geig_in = 1'b0;
        checks++; if (w_fill !== 7'd8) begin failures++; $display("FAIL fp_fill_kept got=%0d exp=8", w_fill); end
        checks++; if (w_drop !== 16'd0) begin failures++; $display("FAIL fp_drop got=%0d exp=0", w_drop); end
        checks++; if (w_ts_data !== exp_s[1]) begin failures++; $display("FAIL fp_head got=%0d exp=%0d", w_ts_data, exp_s[1]); end
        ts_ready = 1'b1;
        n = 1;
        for (int i = 0; i < 11; i++) begin
            if (w_ts_valid) begin
                checks++;
                if (n > 8) begin failures++; $display("FAIL fp_extra_stamp got=%0d exp=none", w_ts_data); end
                else if (w_ts_data !== exp_s[n]) begin failures++; $display("FAIL fp_stamp%0d got=%0d exp=%0d", n, w_ts_data, exp_s[n]); end
                n++;
            end
            @(negedge clk);
        end
        ts_ready = 1'b0;
        checks++; if (n != 9) begin failures++; $display("FAIL fp_drain_count got=%0d exp=8", n - 1); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] exp_s;
        do_reset();
        for (int i = 0; i < 10; i++) pulse(c_gap_fast / 2, c_gap_fast - c_gap_fast / 2);
        idle(3);
        ts_ready = 1'b1;
        idle(3);
        ts_ready = 1'b0;
        checks++; if (w_fill !== 7'd5) begin failures++; $display("FAIL rm_fill_pre got=%0d exp=5", w_fill); end
        checks++; if (w_drop !== 16'd2) begin failures++; $display("FAIL rm_drop_pre got=%0d exp=2", w_drop); end
        rise();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++; if (w_ts_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", w_ts_valid); end
        checks++; if (w_fill !== 7'd0) begin failures++; $display("FAIL rm_fill got=%0d exp=0", w_fill); end
        checks++; if (w_drop !== 16'd0) begin failures++; $display("FAIL rm_drop got=%0d exp=0", w_drop); end
        for (int i = 0; i < 10; i++) begin
            idle(1);
            checks++; if (w_fill !== 7'd0) begin failures++; $display("FAIL rm_held_high_c%0d got=%0d exp=0", i, w_fill); end
        end
        geig_in = 1'b0;
        idle(3);
        exp_s = w_ts + 48'd2;
        pulse(2, 2);
        checks++; if (w_fill !== 7'd1) begin failures++; $display("FAIL rm_new_fill got=%0d exp=1", w_fill); end
        checks++; if (w_ts_data !== exp_s) begin failures++; $display("FAIL rm_new_stamp got=%0d exp=%0d", w_ts_data, exp_s); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 28; i++) pulse(c_gap_fast / 2, c_gap_fast - c_gap_fast / 2);
        idle(3);
        checks++; if (w_drop !== 16'd20) begin failures++; $display("FAIL sat_drop20 got=%0d exp=20", w_drop); end
        checks++; if (w_fill !== 7'd8) begin failures++; $display("FAIL sat_fill got=%0d exp=8", w_fill); end
        // Jump the counter close to its ceiling instead of clocking 65k drops.
        force dut.r_drop_cnt = 16'hFFF0;
        m_drop = 16'hFFF0;
        #1;
        release dut.r_drop_cnt;
        idle(1);
        checks++; if (w_drop !== 16'hFFF0) begin failures++; $display("FAIL sat_preload got=%h exp=fff0", w_drop); end
        for (int i = 0; i < 20; i++) begin
            pulse(c_gap_fast / 2, c_gap_fast - c_gap_fast / 2);
            idle(2);
            checks++; if (w_drop !== m_drop) begin failures++; $display("FAIL sat_step%0d got=%h exp=%h", i, w_drop, m_drop); end
        end
        checks++; if (w_drop !== 16'hFFFF) begin failures++; $display("FAIL sat_final got=%h exp=ffff", w_drop); end
    endtask

    task automatic test_deadtime();
        logic [47:0] got[3];
        logic [47:0] base;
        int          n;
        do_reset();
        ts_ready = 1'b1;
        base = w_ts;
        n = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 0 || i == 20 || i == 50) rise();
            if (i == 5 || i == 25 || i == 55) geig_in = 1'b0;
            @(negedge clk);
            if (w_ts_valid) begin
                if (n < 3) got[n] = w_ts_data;
                n++;
            end
        end
        ts_ready = 1'b0;
        checks++; if (w_drop !== 16'd0) begin failures++; $display("FAIL dt_drop got=%0d exp=0", w_drop); end
        checks++; if (got[0] !== base + 48'd2) begin failures++; $display("FAIL dt_stamp0 got=%0d exp=%0d", got[0], base + 48'd2); end
`ifdef GEIG_DEADTIME_EN
        checks++; if (n != 2) begin failures++; $display("FAIL dt_count got=%0d exp=2", n); end
        checks++; if (got[1] !== base + 48'd52) begin failures++; $display("FAIL dt_stamp1 got=%0d exp=%0d", got[1], base + 48'd52); end
`else
        checks++; if (n != 3) begin failures++; $display("FAIL dt_count got=%0d exp=3", n); end
        checks++; if (got[1] !== base + 48'd22) begin failures++; $display("FAIL dt_stamp1 got=%0d exp=%0d", got[1], base + 48'd22); end
        checks++; if (got[2] !== base + 48'd52) begin failures++; $display("FAIL dt_stamp2 got=%0d exp=%0d", got[2], base + 48'd52); end
`endif
    endtask

    task automatic test_random();
        logic [47:0] exp_data;
        do_reset();
        // Start just below the 48-bit ceiling so stamps wrap mid-run.
        ts_base = 48'hFFFF_FFFF_FE00 - tb_cyc;
        for (int i = 0; i < 1500; i++) begin
            ts_ready = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 99) < 35) begin
                if (geig_in) geig_in = 1'b0;
                else rise();
            end
            @(negedge clk);
            exp_data = (m_fifo.size() != 0) ? m_fifo[0] : 48'd0;
            checks++; if (w_ts_valid !== (m_fifo.size() != 0)) begin failures++; $display("FAIL rnd_valid c%0d got=%b exp=%b", i, w_ts_valid, m_fifo.size() != 0); end
            checks++; if (w_ts_data !== exp_data) begin failures++; $display("FAIL rnd_data c%0d got=%h exp=%h", i, w_ts_data, exp_data); end
            checks++; if (w_fill !== 7'(m_fifo.size())) begin failures++; $display("FAIL rnd_fill c%0d got=%0d exp=%0d", i, w_fill, m_fifo.size()); end
            checks++; if (w_drop !== m_drop) begin failures++; $display("FAIL rnd_drop c%0d got=%0d exp=%0d", i, w_drop, m_drop); end
        end
        geig_in = 1'b0;
        ts_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        geig_in = 1'b0;
        ts_ready = 1'b0;
        ts_base = '0;
        checks = 0;
        failures = 0;
        idle(1);
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_saturation();
        test_deadtime();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
